// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the PC and decode.
// Each cycle it may issue a read at pc_in to a 1-cycle synchronous instruction ROM.
// It buffers the returned {instr, pc} words in a DEPTH-entry FIFO and presents the
// FIFO head to decode over a valid/ready handshake.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               IDLE->RUN; in RUN flushes the buffer (the PC restarts at 0)
//   pc_in               current PC value
//   branch_taken        redirect: flush the buffer and cancel the in-flight read
//   fetch_stall         PC must hold this cycle
//   imem_en/imem_addr   ROM read strobe / address
//   imem_rdata          ROM data, valid the cycle after imem_en
//   instr_valid/ready   decode handshake
//   instr_out/instr_pc  head instruction and its PC
module fetch_unit #(
   parameter int unsigned IW    = 8,
   parameter int unsigned IMW   = 4,
   parameter int unsigned DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [IMW-1:0] pc_in,
   input  logic           branch_taken,
   output logic           fetch_stall,
   output logic           imem_en,
   output logic [IMW-1:0] imem_addr,
   input  logic [IW-1:0]  imem_rdata,
   output logic           instr_valid,
   input  logic           instr_ready,
   output logic [IW-1:0]  instr_out,
   output logic [IMW-1:0] instr_pc
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned OW = CW + 1;

   typedef enum logic {IDLE, RUN} state_t;

   typedef struct packed {
      logic [IW-1:0]  instr;
      logic [IMW-1:0] pc;
   } entry_t;

   state_t         state_q, state_d;
   logic           inflight_q, inflight_d;
   logic [IMW-1:0] inflight_pc_q, inflight_pc_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   entry_t         mem_q [DEPTH];

   logic run, flush, pop, push, issue;
   logic [OW-1:0] occ, lim;

   // Next-state: IDLE leaves only on start; RUN is terminal until reset
   always_comb begin
      state_d = state_q;
      if (state_q == IDLE && start) begin
         state_d = RUN;
      end
   end

   // Issue decision: in-flight word plus current occupancy must fit after this cycle's pop
   always_comb begin
      run   = (state_q == RUN);
      flush = run & (branch_taken | start);
      pop   = instr_valid & instr_ready;
      push  = inflight_q & ~flush;
      occ   = OW'(count_q) + OW'(inflight_q);
      lim   = OW'(DEPTH) + OW'(pop);
      issue = run & ~branch_taken & ~start & (occ < lim);
   end

   assign imem_en     = issue;
   assign imem_addr   = run ? pc_in : '0;
   // A branch moves the PC to the target even though nothing is issued
   assign fetch_stall = run ? (~issue & ~branch_taken) : 1'b1;

   assign instr_valid = (count_q != '0);
   assign instr_out   = mem_q[rd_ptr_q].instr;
   assign instr_pc    = mem_q[rd_ptr_q].pc;

   // FIFO pointer / occupancy and in-flight tracking
   always_comb begin
      inflight_d    = issue;
      inflight_pc_d = issue ? pc_in : inflight_pc_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State and control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // FIFO storage; cleared on reset so the head reads 0 out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= '{instr: imem_rdata, pc: inflight_pc_q};
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for flush/reset, then
// random traffic checked against a queue-based model of the fetch buffer.
module tb_fetch_unit;

   localparam int IW    = 8;
   localparam int IMW   = 4;
   localparam int DEPTH = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [IMW-1:0] pc_in;
   logic           branch_taken = 1'b0;
   logic           fetch_stall;
   logic           imem_en;
   logic [IMW-1:0] imem_addr;
   logic [IW-1:0]  imem_rdata = '0;
   logic           instr_valid;
   logic           instr_ready = 1'b0;
   logic [IW-1:0]  instr_out;
   logic [IMW-1:0] instr_pc;

   fetch_unit #(.IW(IW), .IMW(IMW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pc_in(pc_in),
      .branch_taken(branch_taken), .fetch_stall(fetch_stall),
      .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_out(instr_out), .instr_pc(instr_pc)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: ROM[i] = 0xA0 + i
   logic [IW-1:0] rom [16];
   initial for (int i = 0; i < 16; i++) rom[i] = 8'hA0 + 8'(i);
   always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

   // Environment PC
   logic [IMW-1:0] pc_q = '0;
   logic [IMW-1:0] tgt = '0;
   assign pc_in = pc_q;

   int checks = 0;
   int errors = 0;

   // Reference model: buffered words as queues, one optional in-flight read
   logic [IW-1:0]  mq_i [$];
   logic [IMW-1:0] mq_p [$];
   bit             m_run = 0;
   bit             m_inf = 0;
   logic [IMW-1:0] m_ipc = '0;
   bit             m_pop, m_issue, m_stall, d_stall;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_model();
      int occ;
      m_pop   = (mq_i.size() > 0) && instr_ready;
      occ     = mq_i.size() + int'(m_inf) - int'(m_pop);
      m_issue = m_run && !branch_taken && !start && (occ < DEPTH);
      m_stall = m_run ? (!m_issue && !branch_taken) : 1'b1;
      chk("m_valid", 32'(instr_valid), 32'(mq_i.size() > 0));
      chk("m_en", 32'(imem_en), 32'(m_issue));
      chk("m_stall", 32'(fetch_stall), 32'(m_stall));
      if (m_issue) chk("m_addr", 32'(imem_addr), 32'(pc_q));
      if (mq_i.size() > 0) begin
         chk("m_out", 32'(instr_out), 32'(mq_i[0]));
         chk("m_pc", 32'(instr_pc), 32'(mq_p[0]));
      end
      d_stall = fetch_stall;
   endtask

   task automatic advance();
      bit flush;
      @(posedge clk);
      #1;
      flush = m_run && (branch_taken || start);
      if (flush) begin
         mq_i.delete();
         mq_p.delete();
         m_inf = 0;
      end else begin
         if (m_pop) begin
            void'(mq_i.pop_front());
            void'(mq_p.pop_front());
         end
         if (m_inf) begin
            mq_i.push_back(rom[m_ipc]);
            mq_p.push_back(m_ipc);
         end
         m_inf = m_issue;
         if (m_issue) m_ipc = pc_q;
      end
      if (mq_i.size() > DEPTH) begin
         errors++;
         $display("FAIL overflow: model occupancy %0d exceeds %0d", mq_i.size(), DEPTH);
      end
      if (start) m_run = 1;
      if (start) pc_q = '0;
      else if (branch_taken) pc_q = tgt;
      else if (!d_stall) pc_q = pc_q + 4'd1;
   endtask

   task automatic step();
      @(negedge clk);
      check_model();
      advance();
   endtask

   task automatic model_reset();
      mq_i.delete();
      mq_p.delete();
      m_run = 0;
      m_inf = 0;
      m_ipc = '0;
      pc_q  = '0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
      chk({tag, "_out"}, 32'(instr_out), 32'd0);
      chk({tag, "_pc"}, 32'(instr_pc), 32'd0);
      chk({tag, "_en"}, 32'(imem_en), 32'd0);
      chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
      chk({tag, "_stall"}, 32'(fetch_stall), 32'd1);
   endtask

   typedef struct {
      bit         st, bt, rd;
      logic [3:0] tg;
      bit         v;
      logic [7:0] o;
      logic [3:0] p;
      bit         en;
      logic [3:0] a;
      bit         s;
   } vec_t;

   vec_t tbl [13];

   initial begin
      //           st bt rd tg    v  out    pc    en addr  stall
      tbl[0]  = '{1, 0, 1, 4'd0, 0, 8'h00, 4'd0, 0, 4'd0, 1};
      tbl[1]  = '{0, 0, 1, 4'd0, 0, 8'h00, 4'd0, 1, 4'd0, 0};
      tbl[2]  = '{0, 0, 1, 4'd0, 0, 8'h00, 4'd0, 1, 4'd1, 0};
      tbl[3]  = '{0, 0, 1, 4'd0, 1, 8'hA0, 4'd0, 1, 4'd2, 0};
      tbl[4]  = '{0, 0, 1, 4'd0, 1, 8'hA1, 4'd1, 1, 4'd3, 0};
      tbl[5]  = '{0, 1, 1, 4'd9, 1, 8'hA2, 4'd2, 0, 4'd0, 0};
      tbl[6]  = '{0, 0, 1, 4'd0, 0, 8'h00, 4'd0, 1, 4'd9, 0};
      tbl[7]  = '{0, 0, 1, 4'd0, 0, 8'h00, 4'd0, 1, 4'd10, 0};
      tbl[8]  = '{0, 0, 0, 4'd0, 1, 8'hA9, 4'd9, 0, 4'd0, 1};
      tbl[9]  = '{0, 0, 0, 4'd0, 1, 8'hA9, 4'd9, 0, 4'd0, 1};
      tbl[10] = '{0, 0, 1, 4'd0, 1, 8'hA9, 4'd9, 1, 4'd11, 0};
      tbl[11] = '{0, 0, 1, 4'd0, 1, 8'hAA, 4'd10, 1, 4'd12, 0};
      tbl[12] = '{0, 0, 1, 4'd0, 1, 8'hAB, 4'd11, 1, 4'd13, 0};

      // Reset values while rst_n is held low
      #1;
      chk_reset_outputs("rst0");
      #11 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed table: fill, branch with pop, backpressure and resume
      for (int i = 0; i < 13; i++) begin
         start        = tbl[i].st;
         branch_taken = tbl[i].bt;
         tgt          = tbl[i].tg;
         instr_ready  = tbl[i].rd;
         @(negedge clk);
         chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].v));
         chk($sformatf("tbl%0d_en", i), 32'(imem_en), 32'(tbl[i].en));
         chk($sformatf("tbl%0d_stall", i), 32'(fetch_stall), 32'(tbl[i].s));
         if (tbl[i].v) begin
            chk($sformatf("tbl%0d_out", i), 32'(instr_out), 32'(tbl[i].o));
            chk($sformatf("tbl%0d_pc", i), 32'(instr_pc), 32'(tbl[i].p));
         end
         if (tbl[i].en) chk($sformatf("tbl%0d_addr", i), 32'(imem_addr), 32'(tbl[i].a));
         check_model();
         advance();
      end
      start = 0; branch_taken = 0;

      // Fill the buffer, then restart with start while full
      instr_ready = 0;
      step();
      @(negedge clk);
      chk("full_stall", 32'(fetch_stall), 32'd1);
      chk("full_head", 32'(instr_out), 32'hAC);
      check_model();
      advance();
      start = 1;
      @(negedge clk);
      chk("restart_en", 32'(imem_en), 32'd0);
      check_model();
      advance();
      start = 0; instr_ready = 1;
      @(negedge clk);
      chk("restart_en1", 32'(imem_en), 32'd1);
      chk("restart_addr", 32'(imem_addr), 32'd0);
      chk("restart_flushed", 32'(instr_valid), 32'd0);
      check_model();
      advance();
      step();
      @(negedge clk);
      chk("restart_head", 32'(instr_out), 32'hA0);
      chk("restart_hpc", 32'(instr_pc), 32'd0);
      check_model();
      advance();
      for (int i = 0; i < 3; i++) step();

      // Asynchronous reset between clock edges
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk_reset_outputs("rst1");
      model_reset();
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("idle_en", 32'(imem_en), 32'd0);
      chk("idle_stall", 32'(fetch_stall), 32'd1);
      check_model();
      advance();

      // Random traffic against the model
      start = 1;
      step();
      start = 0;
      for (int i = 0; i < 3000; i++) begin
         start        = ($urandom_range(0, 63) == 0);
         branch_taken = ($urandom_range(0, 11) == 0);
         tgt          = 4'($urandom_range(0, 15));
         instr_ready  = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
